// File: rtl/cpr_sequencer_if.sv
// rtl/cpr_sequencer_if.sv - start pad in, indicator pads and status out of the CPR sequencer
interface cpr_sequencer_if;
  logic       start;
  logic       compress_out;
  logic       breath_out;
  logic       pulse_out;
  logic       sync;
  logic       busy;
  logic [7:0] cycle_count;

  modport master (
    input  start,
    output compress_out, breath_out, pulse_out, sync, busy, cycle_count
  );

  modport slave (
    output start,
    input  compress_out, breath_out, pulse_out, sync, busy, cycle_count
  );
endinterface

// File: rtl/cpr_sequencer.sv
// rtl/cpr_sequencer.sv - CPR timing engine: compressions then breaths per cycle, metronome and sync strobes
module cpr_sequencer #(
  parameter int PRESCALE      = 4,
  parameter int COMP_PERIOD   = 5,
  parameter int COMP_ON       = 2,
  parameter int BREATH_PERIOD = 8,
  parameter int BREATH_ON     = 4,
  parameter int N_COMP        = 3,
  parameter int N_BREATH      = 2,
  parameter int N_CYCLES      = 2
) (
  input  logic            clk,
  input  logic            resetb,
  cpr_sequencer_if.master bus
);

  localparam int PMAX  = (COMP_PERIOD > BREATH_PERIOD) ? COMP_PERIOD : BREATH_PERIOD;
  localparam int NMAX  = (N_COMP > N_BREATH) ? N_COMP : N_BREATH;
  localparam int NCMAX = (N_CYCLES > 1) ? N_CYCLES : 1;
  localparam int TW    = $clog2(PRESCALE + 1);
  localparam int PW    = $clog2(PMAX + 1);
  localparam int IW    = $clog2(NMAX + 1);
  localparam int CW    = $clog2(NCMAX + 1);

  localparam logic [TW-1:0] T_LAST   = TW'(PRESCALE - 1);
  localparam logic [PW-1:0] C_LAST   = PW'(COMP_PERIOD - 1);
  localparam logic [PW-1:0] B_LAST   = PW'(BREATH_PERIOD - 1);
  localparam logic [PW-1:0] C_ON     = PW'(COMP_ON);
  localparam logic [PW-1:0] B_ON     = PW'(BREATH_ON);
  localparam logic [IW-1:0] NC_LAST  = IW'(N_COMP - 1);
  localparam logic [IW-1:0] NB_LAST  = IW'(N_BREATH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(NCMAX - 1);

  typedef enum logic [1:0] {IDLE, COMPRESS, BREATH} state_t;

  state_t        state;
  logic          s1, s2, s2_d, warm1, warm2;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] ph_tick;
  logic [IW-1:0] idx;
  logic [CW-1:0] cyc;
  logic          compress_r, breath_r, pulse_r, sync_r, busy_r;
  logic [7:0]    cycle_cnt_r;

  logic start_rise, start_lvl, tick;
  assign start_rise = s2 & ~s2_d;
  assign start_lvl  = s2;
  assign tick       = (tcnt == T_LAST);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s2_d        <= 1'b0;
      warm1       <= 1'b0;
      warm2       <= 1'b0;
      tcnt        <= '0;
      ph_tick     <= '0;
      idx         <= '0;
      cyc         <= '0;
      compress_r  <= 1'b0;
      breath_r    <= 1'b0;
      pulse_r     <= 1'b0;
      sync_r      <= 1'b0;
      busy_r      <= 1'b0;
      cycle_cnt_r <= 8'd0;
    end else begin
      s1    <= bus.start;
      s2    <= s1;
      warm1 <= 1'b1;
      warm2 <= warm1;
      // Until the synchroniser has flushed its reset zeros, s2_d follows s2's next value,
      // so a start already high at reset release is not mistaken for a rising edge.
      s2_d    <= warm2 ? s2 : s1;
      pulse_r <= 1'b0;
      sync_r  <= 1'b0;
      if (state != IDLE) tcnt <= tick ? '0 : tcnt + 1'b1;

      case (state)
        IDLE: begin
          if (start_rise) begin
            state       <= COMPRESS;
            tcnt        <= '0;
            ph_tick     <= '0;
            idx         <= '0;
            cyc         <= '0;
            cycle_cnt_r <= 8'd0;
            compress_r  <= 1'b1;
            pulse_r     <= 1'b1;
            sync_r      <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        COMPRESS: begin
          if (tick) begin
            if (ph_tick == C_LAST) begin
              ph_tick <= '0;
              if (idx == NC_LAST) begin
                state      <= BREATH;
                idx        <= '0;
                compress_r <= 1'b0;
                breath_r   <= 1'b1;
              end else begin
                idx        <= idx + 1'b1;
                pulse_r    <= 1'b1;
                compress_r <= 1'b1;
              end
            end else begin
              ph_tick    <= ph_tick + 1'b1;
              compress_r <= (ph_tick + 1'b1) < C_ON;
            end
          end
        end
        BREATH: begin
          if (tick) begin
            if (ph_tick == B_LAST) begin
              ph_tick <= '0;
              if (idx == NB_LAST) begin
                idx         <= '0;
                cycle_cnt_r <= cycle_cnt_r + 8'd1;
                cyc         <= cyc + 1'b1;
                if (N_CYCLES != 0 && cyc == CYC_LAST) begin
                  state    <= IDLE;
                  breath_r <= 1'b0;
                  busy_r   <= 1'b0;
                end else begin
                  state      <= COMPRESS;
                  breath_r   <= 1'b0;
                  compress_r <= 1'b1;
                  pulse_r    <= 1'b1;
                  sync_r     <= 1'b1;
                end
              end else begin
                idx      <= idx + 1'b1;
                breath_r <= 1'b1;
              end
            end else begin
              ph_tick  <= ph_tick + 1'b1;
              breath_r <= (ph_tick + 1'b1) < B_ON;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Abort overrides everything above except the cycle count bump on the same edge.
      if (state != IDLE && !start_lvl) begin
        state      <= IDLE;
        compress_r <= 1'b0;
        breath_r   <= 1'b0;
        pulse_r    <= 1'b0;
        sync_r     <= 1'b0;
        busy_r     <= 1'b0;
      end
    end
  end

  assign bus.compress_out = compress_r;
  assign bus.breath_out   = breath_r;
  assign bus.pulse_out    = pulse_r;
  assign bus.sync         = sync_r;
  assign bus.busy         = busy_r;
  assign bus.cycle_count  = cycle_cnt_r;

endmodule

// File: doc/cpr_sequencer.md
Name: cpr_sequencer

Overview:
- Core timing engine of the CPR trainer user project; drives the compress/breath/pulse/sync pads that the chip-level bench observes (mprj_io[14..17]) and consumes the start pad (mprj_io[8]).
- After a start request it runs CPR cycles: N_COMP compressions, then N_BREATH breaths.
- Emits a metronome strobe per compression and a sync strobe per cycle.

Parameters:
- PRESCALE, 4, clk cycles per tick; ≥1. Silicon default; silicon uses ~25000 at 25 MHz.
- COMP_PERIOD, 5, ticks per compression.
- COMP_ON, 2, ticks compress_out is high per compression; 1 ≤ COMP_ON < COMP_PERIOD.
- BREATH_PERIOD, 8, ticks per breath.
- BREATH_ON, 4, ticks breath_out is high per breath; 1 ≤ BREATH_ON < BREATH_PERIOD.
- N_COMP, 3, compressions per cycle; ≥1 (silicon 30).
- N_BREATH, 2, breaths per cycle; ≥1.
- N_CYCLES, 2, cycles per run; 0 = run until start drops.

Ports:
- clk, input, 1: system clock.
- resetb, input, 1: asynchronous active-low reset.
- start, input, 1: asynchronous level from pad; run request.
- compress_out, output, 1: compression indicator.
- breath_out, output, 1: breath indicator.
- pulse_out, output, 1: one-clk metronome strobe at each compression start.
- sync, output, 1: one-clk strobe at each cycle start.
- busy, output, 1: high while not IDLE.
- cycle_count, output, 8: completed cycles this run.

Behaviour:
- Reset (resetb low, async): state IDLE; all outputs 0; cycle_count 0; all counters 0; sync flops 0.
- start path: two-flop synchroniser (s1, s2) plus registered s2_d.
  - start_rise = s2 & ~s2_d.
  - start_lvl = s2.
- All outputs are registered; there are no combinational paths from inputs.
- Tick counter:
  - Counts 0..PRESCALE-1 only when state ≠ IDLE.
  - tick is asserted while the counter = PRESCALE-1.
  - Cleared on entry to COMPRESS from IDLE.
- Counters:
  - ph_tick: ticks within the current compression or breath.
  - idx: compression or breath index.
  - cyc: cycles this run.
  - All counter widths are $clog2(max+1).
- FSM states:
  - IDLE: on start_rise, go to COMPRESS and clear ph_tick, idx, cyc and cycle_count. At that same edge set compress_out=1, pulse_out=1, sync=1, busy=1.
  - COMPRESS: on tick, ph_tick++.
    - compress_out = (ph_tick < COMP_ON).
    - When ph_tick = COMP_PERIOD-1 on tick: ph_tick=0 and idx++.
    - If idx = N_COMP-1, go to BREATH with idx=0; breath_out goes 1 at that edge.
    - Otherwise pulse_out strobes for 1 clk.
  - BREATH: same structure with BREATH_ON and BREATH_PERIOD; compress_out = 0.
    - After the last breath (idx = N_BREATH-1) completes, cycle_count++ (wraps 255→0) and cyc++.
    - If N_CYCLES ≠ 0 and cyc+1 = N_CYCLES, go to IDLE; all outputs drop at that edge, cycle_count holds.
    - Otherwise go to COMPRESS with sync=1 and pulse_out=1 for 1 clk.
- Latency:
  - start is first sampled high at edge E0; outputs go high at edge E2.
  - Completion is exact: total run = N_CYCLES × (N_COMP×COMP_PERIOD + N_BREATH×BREATH_PERIOD) × PRESCALE clk.
- Boundary conditions:
  - Abort: start_lvl = 0 in any non-IDLE state → IDLE at the next edge. All outputs go 0; cycle_count holds the completed cycles.
  - start_rise while busy: ignored.
  - Start held high after a run completes: no restart; a new rising edge is required.
  - Abort and cycle completion on the same edge: abort wins; cycle_count still increments.
  - resetb asserted mid-run: immediate return to IDLE with all outputs 0.
  - Mid-run reset with start held high: no rising edge is seen, so the block stays IDLE.
    - After resetb deasserts, s2_d and s2 both become 1, so start_rise never fires.
    - Restarting requires start to go low, then high.

Test Plan:
- Reset: resetb low with start=1 → all outputs 0, busy 0, cycle_count 0; after release with start held high, block stays IDLE for 100 clk.
- Nominal run (defaults): start rise →
  - compress_out high 8 clk of every 20, three times; pulse_out at clk 0, 20, 40; sync at clk 0.
  - breath_out high 16 of 32, twice.
  - sync again at clk 124; busy falls at clk 248; cycle_count=2.
- Latency: start sampled at edge E0 → compress_out, sync, pulse_out, busy all 1 after edge E2, not earlier.
- Abort: start low during 2nd breath of cycle 1 → all outputs 0 within 3 clk; cycle_count=0; new rise restarts with cycle_count cleared.
- Infinite mode (N_CYCLES=0, N_COMP=1, N_BREATH=1, short periods): run past 256 cycles → cycle_count wraps 255→0; sync every cycle; busy stays 1.
- Glitch: a start pulse of 1 clk, asynchronous to clk → run starts at most once; a second rise while busy has no effect on timing.
